// File: rtl/regfile_pkg.sv
// Shared sizing constants, types and the write-select decoder for the 64x16 register file.
package regfile_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned ADDR_W = 6;
    localparam int unsigned DEPTH  = 64;

    typedef logic [ADDR_W-1:0] rf_addr_t;
    typedef logic [DATA_W-1:0] rf_data_t;
    typedef logic [DEPTH-1:0]  rf_sel_t;

    // One-hot word select; all-zero when the write is not enabled.
    function automatic rf_sel_t rf_decode(input rf_addr_t addr, input logic en);
        rf_sel_t sel;
        sel       = '0;
        sel[addr] = en;
        return sel;
    endfunction

endpackage

// File: rtl/regfile_word.sv
// One storage word of the register file: synchronous clear with priority over load.
module regfile_word
    import regfile_pkg::*;
#(
    parameter int unsigned WIDTH = DATA_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/regfile.sv
// 64x16 register file: one synchronous write port, two combinational read ports, no bypass.
module regfile
    import regfile_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr_0,
    input  logic [ADDR_W-1:0] rd_addr_1,
    output logic [DATA_W-1:0] rd_data_0,
    output logic [DATA_W-1:0] rd_data_1,
    input  logic              VDD,
    input  logic              VSS
);

    rf_sel_t  wr_sel;
    rf_data_t word_q [DEPTH];

    // Supply pins exist only for the hard-macro netlist; this net feeds nothing.
    logic unused_pwr;
    assign unused_pwr = VDD ^ VSS;

    always_comb begin
        wr_sel = rf_decode(wr_addr, wr_en);
    end

    for (genvar g = 0; g < DEPTH; g++) begin : gen_word
        regfile_word #(
            .WIDTH (DATA_W)
        ) u_word (
            .clk  (clk),
            .rst  (rst),
            .load (wr_sel[g]),
            .d    (wr_data),
            .q    (word_q[g])
        );
    end

    // Reads see stored contents only, so a same-cycle write appears after the edge.
    always_comb begin
        rd_data_0 = word_q[rd_addr_0];
        rd_data_1 = word_q[rd_addr_1];
    end

endmodule

// File: tb/tb_regfile.sv
// Self-checking bench for regfile: reference array model plus an expected-value scoreboard.
module tb_regfile;
    import regfile_pkg::*;

    logic     clk = 1'b0;
    logic     rst;
    logic     wr_en;
    rf_addr_t wr_addr;
    rf_data_t wr_data;
    rf_addr_t rd_addr_0;
    rf_addr_t rd_addr_1;
    rf_data_t rd_data_0;
    rf_data_t rd_data_1;
    logic     VDD = 1'b1;
    logic     VSS = 1'b0;

    always #5 clk = ~clk;

    regfile dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_addr_0 (rd_addr_0),
        .rd_addr_1 (rd_addr_1),
        .rd_data_0 (rd_data_0),
        .rd_data_1 (rd_data_1),
        .VDD       (VDD),
        .VSS       (VSS)
    );

    typedef struct {
        string    tag;
        bit       port;
        rf_data_t val;
    } exp_t;

    exp_t        sb_q[$];
    rf_data_t    model [DEPTH];
    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    task automatic check_val(input string tag, input rf_data_t got, input rf_data_t exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input string tag, input bit port, input rf_data_t val);
        exp_t e;
        e.tag  = tag;
        e.port = port;
        e.val  = val;
        sb_q.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_val(e.tag, e.port ? rd_data_1 : rd_data_0, e.val);
        end
    endtask

    // Drive both read addresses away from the clock edge and queue the model's answer.
    task automatic read_pair(input string tag, input rf_addr_t a0, input rf_addr_t a1);
        @(negedge clk);
        rd_addr_0 = a0;
        rd_addr_1 = a1;
        push_exp({tag, "_p0"}, 1'b0, model[a0]);
        push_exp({tag, "_p1"}, 1'b1, model[a1]);
        #1;
        drain();
    endtask

    task automatic write_word(input rf_addr_t a, input rf_data_t d, input logic en);
        @(negedge clk);
        wr_en   = en;
        wr_addr = a;
        wr_data = d;
        @(posedge clk);
        if (en) model[a] = d;
        #1;
        wr_en = 1'b0;
    endtask

    task automatic do_reset_with_write(input rf_addr_t a, input rf_data_t d);
        @(negedge clk);
        rst     = 1'b1;
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        @(posedge clk);
        for (int i = 0; i < int'(DEPTH); i++) model[i] = '0;
        #1;
        rst   = 1'b0;
        wr_en = 1'b0;
    endtask

    initial begin
        rst       = 1'b0;
        wr_en     = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        rd_addr_0 = '0;
        rd_addr_1 = '0;

        // Reset with a write in flight; everything must read zero.
        do_reset_with_write(rf_addr_t'(3), 16'hA5A5);
        for (int i = 0; i < int'(DEPTH); i++) begin
            @(negedge clk);
            rd_addr_0 = rf_addr_t'(i);
            rd_addr_1 = rf_addr_t'(DEPTH - 1 - i);
            push_exp("reset_p0", 1'b0, 16'h0000);
            push_exp("reset_p1", 1'b1, 16'h0000);
            #1;
            drain();
        end

        // Fill with i*0x2408.
        for (int i = 0; i < int'(DEPTH); i++) begin
            write_word(rf_addr_t'(i), 16'(i * 32'h2408), 1'b1);
        end
        for (int i = 0; i < int'(DEPTH); i++) begin
            read_pair("fill", rf_addr_t'(i), rf_addr_t'(i));
        end
        @(negedge clk);
        rd_addr_0 = rf_addr_t'(1);
        rd_addr_1 = rf_addr_t'(2);
        push_exp("fill_a1", 1'b0, 16'h2408);
        push_exp("fill_a2", 1'b1, 16'h4810);
        #1;
        drain();
        @(negedge clk);
        rd_addr_0 = rf_addr_t'(63);
        rd_addr_1 = rf_addr_t'(0);
        push_exp("fill_a63", 1'b0, 16'hDDF8);
        push_exp("fill_a0", 1'b1, 16'h0000);
        #1;
        drain();

        // Disabled writes must leave the fill pattern intact.
        for (int i = 0; i < int'(DEPTH); i++) begin
            write_word(rf_addr_t'(i), 16'(i * 32'h0101), 1'b0);
        end
        for (int i = 0; i < int'(DEPTH); i++) begin
            read_pair("hold", rf_addr_t'(i), rf_addr_t'(DEPTH - 1 - i));
        end

        // Dual-port with port 0 one address behind, wrapping at zero.
        @(negedge clk);
        rd_addr_0 = rf_addr_t'(-1);
        rd_addr_1 = rf_addr_t'(0);
        push_exp("wrap_i0_p0", 1'b0, 16'hDDF8);
        push_exp("wrap_i0_p1", 1'b1, 16'h0000);
        #1;
        drain();
        for (int i = 0; i < int'(DEPTH); i++) begin
            read_pair("wrap", rf_addr_t'(i - 1), rf_addr_t'(i));
        end

        // Collision: old data before the edge, new data after, no bypass.
        write_word(rf_addr_t'(5), 16'h1234, 1'b1);
        @(negedge clk);
        wr_en     = 1'b1;
        wr_addr   = rf_addr_t'(5);
        wr_data   = 16'hBEEF;
        rd_addr_0 = rf_addr_t'(5);
        rd_addr_1 = rf_addr_t'(6);
        push_exp("coll_before", 1'b0, 16'h1234);
        push_exp("coll_other", 1'b1, 16'(6 * 32'h2408));
        #1;
        drain();
        @(posedge clk);
        model[5] = 16'hBEEF;
        #1;
        wr_en = 1'b0;
        push_exp("coll_after", 1'b0, 16'hBEEF);
        push_exp("coll_other_after", 1'b1, 16'(6 * 32'h2408));
        drain();

        // Reset priority over a same-cycle write to a nonzero word.
        read_pair("pre_rst7", rf_addr_t'(7), rf_addr_t'(5));
        do_reset_with_write(rf_addr_t'(7), 16'hFFFF);
        @(negedge clk);
        rd_addr_0 = rf_addr_t'(7);
        rd_addr_1 = rf_addr_t'(5);
        push_exp("rst_prio_a7", 1'b0, 16'h0000);
        push_exp("rst_prio_a5", 1'b1, 16'h0000);
        #1;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
